// File: rtl/pc_fetch_unit.sv
// Program counter and fetch control for the 16-bit instruction memory.
// Pairs each returned word with its byte address and handles stall, branch redirect and halt.
module pc_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'hE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [15:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    output logic              halted,
    output logic [15:0]       instr_count
);

    // state | meaning
    // FILL  | first fetch after reset, nothing displayed yet
    // RUN   | streaming instructions to the decoder
    // HALT  | halt opcode accepted, fetch frozen until reset
    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [ADDR_W-1:0] target;
    logic              valid_next;
    logic              halted_next;
    logic [15:0]       count_next;
    logic              halt_seen;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(2);

    assign if_instr  = imem_data;
    assign target    = {br_target[ADDR_W-1:1], 1'b0};
    assign halt_seen = (imem_data[15:12] == HALT_OP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FILL;
            pc          <= RESET_PC;
            if_pc       <= '0;
            if_valid    <= 1'b0;
            halted      <= 1'b0;
            instr_count <= 16'h0000;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            if_pc       <= imem_addr;
            if_valid    <= valid_next;
            halted      <= halted_next;
            instr_count <= count_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        valid_next  = if_valid;
        halted_next = halted;
        count_next  = instr_count;
        imem_addr   = pc;
        case (state)
            FILL: begin
                pc_next    = pc + STEP;
                valid_next = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (br_taken) begin
                    imem_addr  = target;
                    pc_next    = target + STEP;
                    valid_next = 1'b1;
                end else if (stall) begin
                    imem_addr = if_pc;
                end else if (if_valid) begin
                    count_next = instr_count + 16'd1;
                    if (halt_seen) begin
                        // Park the memory on the halt word itself so the address stays put.
                        imem_addr   = if_pc;
                        state_next  = HALT;
                        valid_next  = 1'b0;
                        halted_next = 1'b1;
                    end else begin
                        pc_next = pc + STEP;
                    end
                end
            end
            HALT: begin
                imem_addr = if_pc;
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

endmodule
